// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and the
// parity helper used by both directions of the link.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_e;

    // Expected line parity bit; unused upper data bits must be zero.
    function automatic logic uart_parity(input logic [8:0] data, input int mode);
        case (mode)
            PARITY_ODD:  return ~^data;
            PARITY_EVEN: return ^data;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Two-flop synchronizer on the serial pin plus a 3-sample majority voter
// centred on the middle of the bit period.
module uart_bit_sampler #(
    parameter int CLKS_PER_BIT = 87,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             i_clock,
    input  logic             i_rst_n,
    input  logic             i_rx_serial,
    input  logic [CNT_W-1:0] i_clk_cnt,
    output logic             o_rx_s,
    output logic             o_bit_vote
);

    localparam int MID = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CNT_W-1:0] CNT_S0 = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_S1 = CNT_W'(MID);

    logic [1:0] sync_q;
    logic       samp0_q;
    logic       samp1_q;

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q  <= 2'b11;
            samp0_q <= 1'b1;
            samp1_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], i_rx_serial};
            if (i_clk_cnt == CNT_S0) samp0_q <= sync_q[1];
            if (i_clk_cnt == CNT_S1) samp1_q <= sync_q[1];
        end
    end

    assign o_rx_s = sync_q[1];

    // Third sample is the live value, so the vote is valid at count MID+1.
    assign o_bit_vote = (samp0_q & samp1_q) | (samp0_q & o_rx_s) | (samp1_q & o_rx_s);

endmodule

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver (5..9 data bits, none/odd/even parity, 1 or 2
// stop bits) with parity/framing/break/overrun reporting and ready/valid output.
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clock,
    input  logic                 i_rst_n,
    input  logic                 i_rx_serial,
    input  logic                 i_rx_ready,
    output logic                 o_rx_dv,
    output logic [DATA_BITS-1:0] o_rx_byte,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_break,
    output logic                 o_rx_active
);

    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("uart_rx_framed: CLKS_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("uart_rx_framed: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $error("uart_rx_framed: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_framed: STOP_BITS must be 1 or 2");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int MID   = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(MID + 1);

    rx_state_e            state_q;
    logic [CNT_W-1:0]     clk_cnt_q;
    logic [3:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q;
    logic                 all_zero_q;
    logic                 rx_dv_q;
    logic [DATA_BITS-1:0] rx_byte_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 break_q;
    logic                 rx_active_q;

    logic rx_s;
    logic bit_vote;
    logic vote_now;
    logic bit_end;
    logic stop_vote;
    logic stop_low;
    logic is_break;
    logic frame_done;

    uart_bit_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_sampler (
        .i_clock     (i_clock),
        .i_rst_n     (i_rst_n),
        .i_rx_serial (i_rx_serial),
        .i_clk_cnt   (clk_cnt_q),
        .o_rx_s      (rx_s),
        .o_bit_vote  (bit_vote)
    );

    assign vote_now = (clk_cnt_q == CNT_VOTE);
    assign bit_end  = (clk_cnt_q == CNT_LAST);

    // A frame ends at the vote of a low stop bit or of the last stop bit.
    always_comb begin
        stop_vote  = (state_q == ST_STOP) && vote_now;
        stop_low   = stop_vote && !bit_vote;
        is_break   = stop_low && all_zero_q && (bit_idx_q == 4'd0);
        frame_done = stop_vote && !is_break &&
                     (!bit_vote || (bit_idx_q == 4'(STOP_BITS - 1)));
    end

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            all_zero_q   <= 1'b0;
            rx_dv_q      <= 1'b0;
            rx_byte_q    <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            break_q      <= 1'b0;
            rx_active_q  <= 1'b0;
        end else begin
            overrun_q   <= 1'b0;
            break_q     <= is_break;
            rx_active_q <= (state_q != ST_IDLE);
            if (rx_dv_q && i_rx_ready) rx_dv_q <= 1'b0;
            if (frame_done) begin
                if (!rx_dv_q || i_rx_ready) begin
                    rx_dv_q      <= 1'b1;
                    rx_byte_q    <= shift_q;
                    parity_err_q <= par_err_q;
                    frame_err_q  <= stop_low;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
            clk_cnt_q <= bit_end ? '0 : clk_cnt_q + 1'b1;

            case (state_q)
                ST_IDLE: begin
                    clk_cnt_q  <= '0;
                    bit_idx_q  <= '0;
                    par_err_q  <= 1'b0;
                    all_zero_q <= 1'b1;
                    if (!rx_s) state_q <= ST_START;
                end
                ST_START: begin
                    if (vote_now && bit_vote) state_q <= ST_IDLE;
                    else if (bit_end)         state_q <= ST_DATA;
                end
                ST_DATA: begin
                    if (vote_now) begin
                        shift_q <= {bit_vote, shift_q[DATA_BITS-1:1]};
                        if (bit_vote) all_zero_q <= 1'b0;
                    end
                    if (bit_end) begin
                        if (bit_idx_q == 4'(DATA_BITS - 1)) begin
                            bit_idx_q <= '0;
                            state_q   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (vote_now) begin
                        if (bit_vote != uart_parity(9'(shift_q), PARITY)) par_err_q <= 1'b1;
                        if (bit_vote) all_zero_q <= 1'b0;
                    end
                    if (bit_end) state_q <= ST_STOP;
                end
                ST_STOP: begin
                    if (is_break)        state_q   <= ST_BRK_WAIT;
                    else if (frame_done) state_q   <= ST_IDLE;
                    else if (bit_end)    bit_idx_q <= bit_idx_q + 4'd1;
                end
                ST_BRK_WAIT: begin
                    clk_cnt_q <= '0;
                    if (rx_s) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_rx_dv      = rx_dv_q;
    assign o_rx_byte    = rx_byte_q;
    assign o_parity_err = parity_err_q;
    assign o_frame_err  = frame_err_q;
    assign o_overrun    = overrun_q;
    assign o_break      = break_q;
    assign o_rx_active  = rx_active_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: four instances (8N1, 8E1, 8N2, 7O1) at 16 clocks/bit,
// checked against a frame-level reference model.
module tb_uart_rx_framed;

    localparam int CPB = 16;
    localparam int NK  = 4;
    localparam int DB [NK] = '{8, 8, 8, 7};
    localparam int PM [NK] = '{0, 2, 0, 1};
    localparam int SB [NK] = '{1, 1, 2, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NK-1:0] rx_v  = '1;
    logic [NK-1:0] rdy_v = '1;

    logic dv0, dv1, dv2, dv3, pe0, pe1, pe2, pe3, fe0, fe1, fe2, fe3;
    logic ov0, ov1, ov2, ov3, bk0, bk1, bk2, bk3, ac0, ac1, ac2, ac3;
    logic [7:0] b0, b1, b2;
    logic [6:0] b3;

    logic [NK-1:0] dv_v, pe_v, fe_v, ov_v, bk_v, ac_v;
    logic [8:0]    byt [NK];

    always #5 clk = ~clk;

    uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .i_clock(clk), .i_rst_n(rst_n), .i_rx_serial(rx_v[0]), .i_rx_ready(rdy_v[0]),
        .o_rx_dv(dv0), .o_rx_byte(b0), .o_parity_err(pe0), .o_frame_err(fe0),
        .o_overrun(ov0), .o_break(bk0), .o_rx_active(ac0));
    uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .i_clock(clk), .i_rst_n(rst_n), .i_rx_serial(rx_v[1]), .i_rx_ready(rdy_v[1]),
        .o_rx_dv(dv1), .o_rx_byte(b1), .o_parity_err(pe1), .o_frame_err(fe1),
        .o_overrun(ov1), .o_break(bk1), .o_rx_active(ac1));
    uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .i_clock(clk), .i_rst_n(rst_n), .i_rx_serial(rx_v[2]), .i_rx_ready(rdy_v[2]),
        .o_rx_dv(dv2), .o_rx_byte(b2), .o_parity_err(pe2), .o_frame_err(fe2),
        .o_overrun(ov2), .o_break(bk2), .o_rx_active(ac2));
    uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7o1 (
        .i_clock(clk), .i_rst_n(rst_n), .i_rx_serial(rx_v[3]), .i_rx_ready(rdy_v[3]),
        .o_rx_dv(dv3), .o_rx_byte(b3), .o_parity_err(pe3), .o_frame_err(fe3),
        .o_overrun(ov3), .o_break(bk3), .o_rx_active(ac3));

    assign dv_v = {dv3, dv2, dv1, dv0};
    assign pe_v = {pe3, pe2, pe1, pe0};
    assign fe_v = {fe3, fe2, fe1, fe0};
    assign ov_v = {ov3, ov2, ov1, ov0};
    assign bk_v = {bk3, bk2, bk1, bk0};
    assign ac_v = {ac3, ac2, ac1, ac0};

    always_comb begin
        byt[0] = {1'b0, b0};
        byt[1] = {1'b0, b1};
        byt[2] = {1'b0, b2};
        byt[3] = {2'b0, b3};
    end

    typedef struct {
        int         k;
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } word_t;

    typedef struct {
        int         k;
        logic [8:0] data;
        logic       flip_par;
        logic       stop_low;
        int         glitch;
        logic [8:0] exp_byte;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    word_t gotq[$];
    int dv_cyc [NK] = '{default: 0};
    int ov_cyc [NK] = '{default: 0};
    int bk_cyc [NK] = '{default: 0};
    int ac_cyc [NK] = '{default: 0};
    int n_tests = 0;
    int n_fail  = 0;

    // Accepted words are captured at the handshake; pulses are counted per cycle.
    always @(negedge clk) begin
        for (int k = 0; k < NK; k++) begin
            if (dv_v[k]) dv_cyc[k]++;
            if (ov_v[k]) ov_cyc[k]++;
            if (bk_v[k]) bk_cyc[k]++;
            if (ac_v[k]) ac_cyc[k]++;
            if (dv_v[k] && rdy_v[k]) gotq.push_back('{k, byt[k], pe_v[k], fe_v[k]});
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic model_par(input logic [8:0] d, input int db, input int mode);
        int ones = 0;
        for (int i = 0; i < db; i++) ones += int'(d[i]);
        if (mode == 2) return logic'(ones % 2);
        if (mode == 1) return logic'(1 - (ones % 2));
        return 1'b0;
    endfunction

    task automatic send_frame(input int k, input logic [8:0] data, input logic flip_par,
                              input logic stop_low, input int glitch);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DB[k]; i++) bits.push_back(data[i]);
        if (PM[k] != 0) bits.push_back(model_par(data, DB[k], PM[k]) ^ flip_par);
        for (int s = 0; s < SB[k]; s++) bits.push_back((s == 0 && stop_low) ? 1'b0 : 1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            rx_v[k] = bits[b];
            for (int c = 0; c < CPB; c++) begin
                if (glitch >= 0 && b == glitch + 1 && c == 8) rx_v[k] = ~bits[b];
                if (glitch >= 0 && b == glitch + 1 && c == 9) rx_v[k] = bits[b];
                tick(1);
            end
        end
        rx_v[k] = 1'b1;
        tick(2 * CPB);
    endtask

    task automatic wait_word(input int k, input string name, input logic [8:0] eb,
                             input logic epe, input logic efe);
        word_t w;
        int t = 0;
        while (gotq.size() == 0 && t < 8 * CPB) begin
            @(negedge clk);
            t++;
        end
        if (gotq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no word received within %0d cycles, expected %0h", name, t, eb);
        end else begin
            w = gotq.pop_front();
            check({name, ".inst"}, w.k, k);
            check({name, ".byte"}, w.data, eb);
            check({name, ".perr"}, w.pe, epe);
            check({name, ".ferr"}, w.fe, efe);
        end
    endtask

    vec_t vecs[$];

    initial begin
        int snap, snap2;
        logic [8:0] d;
        logic flip, sl, ps, brk;
        int k;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NK; i++) begin
            check($sformatf("reset.dv%0d", i), dv_v[i], 0);
            check($sformatf("reset.byte%0d", i), byt[i], 0);
            check($sformatf("reset.flags%0d", i), {pe_v[i], fe_v[i], ov_v[i], bk_v[i]}, 0);
            check($sformatf("reset.active%0d", i), ac_v[i], 0);
        end
        rst_n = 1'b1;
        tick(4);

        vecs.push_back('{0, 9'h0AB, 1'b0, 1'b0, -1, 9'h0AB, 1'b0, 1'b0});
        vecs.push_back('{1, 9'h0AB, 1'b1, 1'b0, -1, 9'h0AB, 1'b1, 1'b0});
        vecs.push_back('{1, 9'h0AB, 1'b0, 1'b0, -1, 9'h0AB, 1'b0, 1'b0});
        vecs.push_back('{2, 9'h055, 1'b0, 1'b1, -1, 9'h055, 1'b0, 1'b1});
        vecs.push_back('{2, 9'h00F, 1'b0, 1'b0, -1, 9'h00F, 1'b0, 1'b0});
        vecs.push_back('{3, 9'h05A, 1'b0, 1'b0, -1, 9'h05A, 1'b0, 1'b0});
        vecs.push_back('{0, 9'h000, 1'b0, 1'b0, -1, 9'h000, 1'b0, 1'b0});
        vecs.push_back('{3, 9'h07F, 1'b0, 1'b1, -1, 9'h07F, 1'b0, 1'b1});
        vecs.push_back('{0, 9'h0C3, 1'b0, 1'b0,  3, 9'h0C3, 1'b0, 1'b0});
        vecs.push_back('{1, 9'h0C3, 1'b1, 1'b1, -1, 9'h0C3, 1'b1, 1'b1});
        foreach (vecs[i]) begin
            snap = dv_cyc[vecs[i].k];
            send_frame(vecs[i].k, vecs[i].data, vecs[i].flip_par, vecs[i].stop_low, vecs[i].glitch);
            wait_word(vecs[i].k, $sformatf("vec%0d", i), vecs[i].exp_byte, vecs[i].exp_pe, vecs[i].exp_fe);
            check($sformatf("vec%0d.dv_cycles", i), dv_cyc[vecs[i].k] - snap, 1);
        end

        // Overrun: second frame dropped while the first is held.
        rdy_v[0] = 1'b0;
        snap = ov_cyc[0];
        send_frame(0, 9'h011, 1'b0, 1'b0, -1);
        send_frame(0, 9'h022, 1'b0, 1'b0, -1);
        @(negedge clk);
        check("ovr.dv_held", dv_v[0], 1);
        check("ovr.byte_held", byt[0], 9'h011);
        check("ovr.pulses", ov_cyc[0] - snap, 1);
        rdy_v[0] = 1'b1;
        wait_word(0, "ovr.accept", 9'h011, 1'b0, 1'b0);
        tick(3 * CPB);
        check("ovr.no_second", gotq.size(), 0);
        check("ovr.dv_low", dv_v[0], 0);

        // Break: 12 bit-times low, 1 high, then a clean frame.
        snap = bk_cyc[0];
        snap2 = dv_cyc[0];
        rx_v[0] = 1'b0;
        tick(12 * CPB);
        rx_v[0] = 1'b1;
        tick(CPB);
        check("brk.pulses", bk_cyc[0] - snap, 1);
        check("brk.no_dv", dv_cyc[0] - snap2, 0);
        send_frame(0, 9'h03C, 1'b0, 1'b0, -1);
        wait_word(0, "brk.after", 9'h03C, 1'b0, 1'b0);

        // False start: 3-clock low pulse.
        snap = ac_cyc[0];
        snap2 = dv_cyc[0];
        rx_v[0] = 1'b0;
        tick(3);
        rx_v[0] = 1'b1;
        tick(3 * CPB);
        check("fstart.no_dv", dv_cyc[0] - snap2, 0);
        check("fstart.active_short", (ac_cyc[0] - snap) <= CPB, 1);
        check("fstart.active_now", ac_v[0], 0);

        // Reset in the middle of a 7O1 frame while a word is held.
        rdy_v[3] = 1'b0;
        send_frame(3, 9'h02A, 1'b0, 1'b0, -1);
        @(negedge clk);
        check("rst.held_before", dv_v[3], 1);
        rx_v[3] = 1'b0;
        tick(2 * CPB);
        rx_v[3] = 1'b1;
        tick(CPB / 2);
        @(negedge clk);
        check("rst.active_in_data", ac_v[3], 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst.dv", dv_v[3], 0);
        check("rst.byte", byt[3], 0);
        check("rst.flags", {pe_v[3], fe_v[3], ov_v[3], bk_v[3]}, 0);
        check("rst.active", ac_v[3], 0);
        rx_v[3] = 1'b1;
        rdy_v = '1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        send_frame(3, 9'h05A, 1'b0, 1'b0, -1);
        wait_word(3, "rst.after", 9'h05A, 1'b0, 1'b0);
        check("rst.no_stale", gotq.size(), 0);

        // Randomised frames against the frame-level model.
        for (int i = 0; i < 24; i++) begin
            k = $urandom_range(0, NK - 1);
            d = 9'($urandom) & 9'((1 << DB[k]) - 1);
            if ($urandom_range(0, 5) == 0) d = '0;
            flip = (PM[k] != 0) && ($urandom_range(0, 3) == 0);
            sl = ($urandom_range(0, 4) == 0);
            ps = model_par(d, DB[k], PM[k]) ^ flip;
            brk = sl && (d == 0) && (PM[k] == 0 || ps == 1'b0);
            snap = bk_cyc[k];
            send_frame(k, d, flip, sl, -1);
            if (brk) begin
                check($sformatf("rnd%0d.break", i), bk_cyc[k] - snap, 1);
                check($sformatf("rnd%0d.no_word", i), gotq.size(), 0);
            end else begin
                wait_word(k, $sformatf("rnd%0d", i), d, flip, sl);
                check($sformatf("rnd%0d.no_break", i), bk_cyc[k] - snap, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
